// File: rtl/lane_deser_8.sv
// lane_deser_8: rebuilds a LANES*LANE_W-bit word from LANE_W-bit lane beats.
// Lanes arrive in order 0..LANES-1 over valid/ready; each beat is bit-reversed on write.
// The finished word is held on a valid/ready output until the consumer pops it.
module lane_deser_8 #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 2,
    localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int unsigned WORD_W = LANES * LANE_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [LANE_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [WORD_W-1:0] o_out_data,
    output logic [CNT_W-1:0]  o_lane_cnt
);

    typedef enum logic [0:0] {StFill, StFull} state_e;

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_lane_cnt;
    logic [CNT_W-1:0]   w_lane_cnt_nxt;
    logic [WORD_W-1:0]  r_data;
    logic [WORD_W-1:0]  w_data_nxt;
    logic [LANE_W-1:0]  w_rev;
    logic               w_beat;
    logic               w_write;

    // In FULL the input is only ready when the held word leaves on the same edge.
    assign o_in_ready  = (r_state == StFill) || i_out_ready;
    assign o_out_valid = (r_state == StFull);
    assign o_out_data  = r_data;
    assign o_lane_cnt  = r_lane_cnt;

    // clear shows in_ready but suppresses the write.
    assign w_beat = i_in_valid && o_in_ready && !i_clear;

    // Bit-reverse the incoming beat: lane bit j takes in_data[LANE_W-1-j].
    always_comb begin
        w_rev = '0;
        for (int j = 0; j < LANE_W; j++) begin
            w_rev[j] = i_in_data[LANE_W-1-j];
        end
    end

    // Next-state, lane counter and lane write decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_lane_cnt_nxt = r_lane_cnt;
        w_write        = 1'b0;
        if (i_clear) begin
            w_state_nxt    = StFill;
            w_lane_cnt_nxt = '0;
        end else begin
            unique case (r_state)
                StFill: begin
                    if (w_beat) begin
                        w_write = 1'b1;
                        if (r_lane_cnt == LAST_LANE) begin
                            w_lane_cnt_nxt = '0;
                            w_state_nxt    = StFull;
                        end else begin
                            w_lane_cnt_nxt = r_lane_cnt + CNT_W'(1);
                        end
                    end
                end
                StFull: begin
                    // lane_cnt is 0 here, so a beat on the pop edge lands in lane 0.
                    if (i_out_ready) begin
                        w_state_nxt = StFill;
                        if (w_beat) begin
                            w_write        = 1'b1;
                            w_lane_cnt_nxt = CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt    = StFill;
                    w_lane_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Write the reversed beat into the lane selected by lane_cnt; other lanes keep old data.
    always_comb begin
        w_data_nxt = r_data;
        if (w_write) begin
            for (int k = 0; k < LANES; k++) begin
                if (CNT_W'(k) == r_lane_cnt) begin
                    w_data_nxt[k*LANE_W +: LANE_W] = w_rev;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StFill;
            r_lane_cnt <= '0;
            r_data     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lane_cnt <= w_lane_cnt_nxt;
            r_data     <= w_data_nxt;
        end
    end

endmodule
